// File: rtl/rr_fifo_scheduler.sv
// rr_fifo_scheduler
//   Moves words from four first-word-fall-through input FIFOs to four output
//   FIFOs over one shared registered bus. Arbitration is round-robin with a
//   per-input burst quantum. The destination of a word is held in its top two
//   bits.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   enable              scheduling allowed
//   in_empty[3:0]       input FIFO empty flags
//   in_FIFO_0..3        input FIFO head words
//   out_almost_full     output FIFO almost-full flags (sampled unregistered)
//   pop[3:0]            one-hot pop to input FIFOs (combinational)
//   push[3:0]           one-hot push to output FIFOs (registered)
//   data_out            word for the output FIFOs, valid while push != 0
//   grant_idx           index of the last granted input
//   busy                FSM is in RUN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grants; enters RUN when enabled and any input eligible
// RUN   | one grant per cycle while enabled and something is eligible
module rr_fifo_scheduler #(
  parameter int unsigned BURST_MAX = 2,
  parameter int unsigned DATA_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        in_empty,
  input  logic [DATA_W-1:0] in_FIFO_0,
  input  logic [DATA_W-1:0] in_FIFO_1,
  input  logic [DATA_W-1:0] in_FIFO_2,
  input  logic [DATA_W-1:0] in_FIFO_3,
  input  logic [3:0]        out_almost_full,
  output logic [3:0]        pop,
  output logic [3:0]        push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant_idx,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         burst_q, burst_d;
  logic [3:0]         push_q, push_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         grant_q, grant_d;

  logic [DATA_W-1:0]  head [4];
  logic [1:0]         dest [4];
  logic [3:0]         eligible;
  logic               any_elig;
  logic [1:0]         g;
  logic [1:0]         idx;
  logic               found;
  logic               grant_vld;
  logic [3:0]         n;

  assign head[0] = in_FIFO_0;
  assign head[1] = in_FIFO_1;
  assign head[2] = in_FIFO_2;
  assign head[3] = in_FIFO_3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dest[i]     = head[i][DATA_W-1 -: 2];
      eligible[i] = !in_empty[i] && !out_almost_full[dest[i]];
    end
  end

  assign any_elig = |eligible;

  // First eligible input searching upward from ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    g     = ptr_q;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  // Entry cycle (still IDLE) never grants; enable gates pop combinationally.
  assign grant_vld = (state_q == RUN) && enable && any_elig;
  assign n         = (g == ptr_q) ? burst_q + 4'd1 : 4'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    push_d  = '0;
    data_d  = data_q;
    grant_d = grant_q;
    pop     = '0;

    case (state_q)
      IDLE: if (enable && any_elig) state_d = RUN;
      RUN:  if (!enable || !any_elig) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_vld) begin
      pop     = 4'b0001 << g;
      push_d  = 4'b0001 << dest[g];
      data_d  = head[g];
      grant_d = g;
      // Quantum used up: rotate past this input so the next one gets a turn.
      if (n == BURST_LIM) begin
        ptr_d   = g + 2'd1;
        burst_d = '0;
      end else begin
        ptr_d   = g;
        burst_d = n;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      burst_q <= '0;
      push_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      push_q  <= push_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign push      = push_q;
  assign data_out  = data_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_rr_fifo_scheduler.sv
module tb_rr_fifo_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] in_empty;
  logic [9:0] in_FIFO_0, in_FIFO_1, in_FIFO_2, in_FIFO_3;
  logic [3:0] out_almost_full;
  logic [3:0] pop;
  logic [3:0] push;
  logic [9:0] data_out;
  logic [1:0] grant_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rr_fifo_scheduler #(.BURST_MAX(2), .DATA_W(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_empty(in_empty),
    .in_FIFO_0(in_FIFO_0), .in_FIFO_1(in_FIFO_1),
    .in_FIFO_2(in_FIFO_2), .in_FIFO_3(in_FIFO_3),
    .out_almost_full(out_almost_full), .pop(pop), .push(push),
    .data_out(data_out), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  logic [9:0] w   [4] = '{10'h011, 10'h122, 10'h233, 10'h344};

  initial begin
    // 1: reset with all inputs non-empty and enable high
    reset = 1'b1; enable = 1'b1; in_empty = 4'b0000; out_almost_full = 4'b0000;
    in_FIFO_0 = w[0]; in_FIFO_1 = w[1]; in_FIFO_2 = w[2]; in_FIFO_3 = w[3];
    tick(); tick();
    chk("rst_pop",   32'(pop), 32'h0);
    chk("rst_push",  32'(push), 32'h0);
    chk("rst_data",  32'(data_out), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_pop", 32'(pop), 32'h0);
    tick();
    chk("entry_busy", 32'(busy), 32'h1);

    // 2: full round-robin with burst quantum 2
    for (int k = 0; k < 9; k++) begin
      chk("rr_pop", 32'(pop), 32'(4'b0001 << seq[k]));
      if (k == 0) begin
        chk("rr_push0", 32'(push), 32'h0);
      end else begin
        chk("rr_push",  32'(push), 32'(4'b0001 << seq[k-1]));
        chk("rr_data",  32'(data_out), 32'(w[seq[k-1]]));
        chk("rr_grant", 32'(grant_idx), 32'(seq[k-1]));
      end
      tick();
    end

    // 5: enable drops mid-traffic; ptr=0, burst=1 retained
    enable = 1'b0;
    #1;
    chk("dis_pop",   32'(pop), 32'h0);
    chk("dis_trail", 32'(push), 32'h1);
    chk("dis_data",  32'(data_out), 32'(w[0]));
    tick();
    chk("dis_busy",  32'(busy), 32'h0);
    chk("dis_push",  32'(push), 32'h0);
    enable = 1'b1;
    #1;
    chk("reen_idle_pop", 32'(pop), 32'h0);
    tick();
    chk("reen_pop0", 32'(pop), 32'b0001);
    tick();
    chk("reen_pop1", 32'(pop), 32'b0010);
    chk("reen_push", 32'(push), 32'b0001);
    enable = 1'b0;
    tick(); tick();

    // 3: single input with word 2A5
    in_empty = 4'b1011; in_FIFO_2 = 10'h2A5; enable = 1'b1;
    tick();
    chk("single_pop", 32'(pop), 32'b0100);
    tick();
    chk("single_push",  32'(push), 32'b0100);
    chk("single_data",  32'(data_out), 32'h2A5);
    chk("single_grant", 32'(grant_idx), 32'h2);
    enable = 1'b0;
    #1;
    tick();

    // 4: destination back-pressure on dest 3
    in_FIFO_0 = 10'h3C0; in_FIFO_1 = 10'h3C1; in_FIFO_2 = 10'h1C2;
    in_empty = 4'b1000; out_almost_full = 4'b1000; enable = 1'b1;
    tick();
    chk("bp_pop_a", 32'(pop), 32'b0100);
    tick();
    chk("bp_pop_b", 32'(pop), 32'b0100);
    chk("bp_push",  32'(push), 32'b0010);
    chk("bp_data",  32'(data_out), 32'h1C2);
    in_empty = 4'b1100; out_almost_full = 4'b0000;
    #1;
    chk("rel_pop0", 32'(pop), 32'b0001);
    tick();
    chk("rel_pop1", 32'(pop), 32'b0001);
    chk("rel_push", 32'(push), 32'b1000);
    chk("rel_data", 32'(data_out), 32'h3C0);
    tick();
    chk("rel_pop2", 32'(pop), 32'b0010);
    tick();
    chk("rel_pop3",   32'(pop), 32'b0010);
    chk("rel_grant3", 32'(grant_idx), 32'h1);
    tick();
    chk("rel_pop4",   32'(pop), 32'b0001);
    chk("rel_data4",  32'(data_out), 32'h3C1);

    // 6: async reset between edges while push is active
    chk("pre_rst_push", 32'(push), 32'b1000);
    #2 reset = 1'b1;
    #1;
    chk("arst_push", 32'(push), 32'h0);
    chk("arst_pop",  32'(pop), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    reset = 1'b0;
    in_FIFO_3 = 10'h0F3; in_empty = 4'b0101;
    tick();
    chk("post_rst_pop", 32'(pop), 32'b0010);
    tick();
    chk("post_rst_push",  32'(push), 32'b1000);
    chk("post_rst_data",  32'(data_out), 32'h3C1);
    chk("post_rst_grant", 32'(grant_idx), 32'h1);
    chk("post_rst_pop2",  32'(pop), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
